aurora_cmd_splitter: RTL

AURORA_CMD_SPLITTER -- requirements
Module: aurora_cmd_splitter

---
 rtl/aurora_cmd_pkg.sv | 14 +
 rtl/cmd_rd_tracker.sv | 37 +++
 rtl/aurora_cmd_splitter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/aurora_cmd_pkg.sv
// Shared types and constants for the Aurora command splitter.
// Holds the input FSM state encoding and the outstanding-read counter width.
package aurora_cmd_pkg;

  // Wide enough for the largest legal MAX_READS (15).
  localparam int RD_CNT_W = 4;

  typedef enum logic [1:0] {
    S_ADDR = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2
  } in_state_e;

endpackage

// File: rtl/cmd_rd_tracker.sv
// Outstanding-read counter for the command splitter.
// Counts read addresses issued minus read responses retired.
// A retire pulse at zero is ignored. If an issue and a retire arrive together, the count is unchanged.
module cmd_rd_tracker
  import aurora_cmd_pkg::*;
#(
  parameter int MAX_READS = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                inc,
  input  logic                dec,
  output logic [RD_CNT_W-1:0] count,
  output logic                full
);

  localparam logic [RD_CNT_W-1:0] MAX_C = RD_CNT_W'(MAX_READS);

  logic dec_eff;

  assign dec_eff = dec && (count != '0);
  assign full    = (count == MAX_C);

  // Up/down count of reads in flight; a retire at zero has no effect.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else begin
      case ({inc, dec_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aurora_cmd_splitter.sv
// Aurora command splitter: turns 1-beat frames into reads and 2-beat frames into writes.
// The result goes into a single output slot that feeds the address and write-data streams.
// A frame that is too long (or that fails the keep check) is dropped with one frame_err pulse.
// Optional macro AURORA_CMD_KEEP_CHECK_EN: when defined, any beat with a partial tkeep drops its frame.
//
// state  | meaning
// S_ADDR | waiting for the first beat of a frame
// S_DATA | first beat held, waiting for the write-data beat
// S_DROP | discarding beats until tlast
module aurora_cmd_splitter
  import aurora_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_READS  = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_cmd_addr_tdata,
  output logic                    m_cmd_addr_tvalid,
  input  logic                    m_cmd_addr_tready,
  output logic [DATA_WIDTH-1:0]   m_cmd_data_tdata,
  output logic                    m_cmd_data_tvalid,
  input  logic                    m_cmd_data_tready,
  input  logic                    rd_done,
  output logic [RD_CNT_W-1:0]     rd_outstanding,
  output logic                    frame_err
);

  in_state_e             state_q, state_d;
  logic                  run_q;
  logic                  addr_vld_q, data_vld_q, is_read_q;
  logic [DATA_WIDTH-1:0] addr_q, data_q;
  logic [DATA_WIDTH-2:0] hold_q;
  logic                  frame_err_q;

  logic slot_free, rd_full, keep_bad, in_hs;
  logic err_now, load_read, load_write, load_hold;
  logic addr_hs, data_hs;

  assign slot_free = !addr_vld_q && !data_vld_q;
  assign in_hs     = s_axis_tvalid && s_axis_tready;
  assign addr_hs   = addr_vld_q && m_cmd_addr_tready;
  assign data_hs   = data_vld_q && m_cmd_data_tready;

`ifdef AURORA_CMD_KEEP_CHECK_EN
  assign keep_bad = (s_axis_tkeep != '1);
`else
  // tkeep is not checked in this build.
  assign keep_bad = 1'b0 & (|s_axis_tkeep);
`endif

  // Input FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= S_ADDR;
    else          state_q <= state_d;
  end

  // run_q holds tready low while in reset and for the first cycle after release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  // Next-state logic, input ready, and the decision to load the slot.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    err_now       = 1'b0;
    load_read     = 1'b0;
    load_write    = 1'b0;
    load_hold     = 1'b0;
    case (state_q)
      S_ADDR: begin
        // A read beat stalls while the read window is full.
        s_axis_tready = run_q && slot_free && !(s_axis_tvalid && s_axis_tlast && rd_full);
        if (in_hs) begin
          if (keep_bad) begin
            err_now = 1'b1;
            state_d = s_axis_tlast ? S_ADDR : S_DROP;
          end else if (s_axis_tlast) begin
            load_read = 1'b1;
          end else begin
            load_hold = 1'b1;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        s_axis_tready = run_q && slot_free;
        if (in_hs) begin
          if (keep_bad || !s_axis_tlast) begin
            err_now = 1'b1;
            state_d = s_axis_tlast ? S_ADDR : S_DROP;
          end else begin
            load_write = 1'b1;
            state_d    = S_ADDR;
          end
        end
      end
      S_DROP: begin
        s_axis_tready = run_q;
        if (in_hs && s_axis_tlast) state_d = S_ADDR;
      end
      default: state_d = S_ADDR;
    endcase
  end

  // Output slot: loaded only when free; each flag clears on its own handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= '0;
    end else begin
      if (addr_hs) addr_vld_q <= 1'b0;
      if (data_hs) data_vld_q <= 1'b0;
      if (load_hold) hold_q <= s_axis_tdata[DATA_WIDTH-2:0];
      if (load_read) begin
        addr_vld_q <= 1'b1;
        is_read_q  <= 1'b1;
        addr_q     <= {1'b1, s_axis_tdata[DATA_WIDTH-2:0]};
      end
      if (load_write) begin
        addr_vld_q <= 1'b1;
        data_vld_q <= 1'b1;
        is_read_q  <= 1'b0;
        addr_q     <= {1'b0, hold_q};
        data_q     <= s_axis_tdata;
      end
    end
  end

  // Register the drop indication so frame_err is a clean one-cycle pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) frame_err_q <= 1'b0;
    else          frame_err_q <= err_now;
  end

  cmd_rd_tracker #(
    .MAX_READS (MAX_READS)
  ) u_rd_tracker (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (addr_hs && is_read_q),
    .dec     (rd_done),
    .count   (rd_outstanding),
    .full    (rd_full)
  );

  assign m_cmd_addr_tdata  = addr_q;
  assign m_cmd_addr_tvalid = addr_vld_q;
  assign m_cmd_data_tdata  = data_q;
  assign m_cmd_data_tvalid = data_vld_q;
  assign frame_err         = frame_err_q;

endmodule
